// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - board keys and counter-chain control signals of the stopwatch sequencer
interface stopwatch_ctrl_if;
    logic [3:0] KEY;
    logic       tick;
    logic       clear;
    logic       display_hold;
    logic       running;
    logic [1:0] state;

    modport master (
        output KEY,
        input  tick,
        input  clear,
        input  display_hold,
        input  running,
        input  state
    );

    modport slave (
        input  KEY,
        output tick,
        output clear,
        output display_hold,
        output running,
        output state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - key debounce plus start/stop/lap/clear sequencer driving the centisecond counter chain
module stopwatch_ctrl #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    stopwatch_ctrl_if.slave   bus
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PW-1:0]  PRE_MAX = PW'(DIV - 1);
    localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUNNING = 2'b01,
        S_PAUSED  = 2'b10,
        S_LAP     = 2'b11
    } state_t;

    // Key 3 has no function; only start/stop, lap and clear go through the input path.
    logic [2:0]     sync1;
    logic [2:0]     sync2;
    logic [2:0]     deb;
    logic [2:0]     deb_d;
    logic [2:0]     press_q;
    logic [DBW-1:0] db_cnt [3];

    state_t         state_q;
    state_t         next_state;
    logic           do_clear;
    logic [PW-1:0]  pre_q;
    logic           tick_q;
    logic           clear_q;
    logic           running_q;
    logic           hold_q;

    logic           ev_clear;
    logic           ev_start;
    logic           ev_lap;

    // Synchronize raw keys, debounce each press level and register one-cycle press events.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1   <= '1;
            sync2   <= '1;
            deb     <= '0;
            deb_d   <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= bus.KEY[2:0];
            sync2   <= sync1;
            deb_d   <= deb;
            press_q <= deb & ~deb_d;
            for (int i = 0; i < 3; i++) begin
                if (~sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only the highest-priority event of a cycle reaches the FSM: clear, then start, then lap.
    assign ev_clear = press_q[2];
    assign ev_start = press_q[0] & ~press_q[2];
    assign ev_lap   = press_q[1] & ~press_q[0] & ~press_q[2];

    // Next-state and clear-request decode for the start/stop/lap/clear sequencer.
    always_comb begin
        next_state = state_q;
        do_clear   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ev_clear) begin
                    do_clear = 1'b1;
                end else if (ev_start) begin
                    next_state = S_RUNNING;
                end
            end
            S_RUNNING: begin
                if (ev_start) begin
                    next_state = S_PAUSED;
                end else if (ev_lap) begin
                    next_state = S_LAP;
                end
            end
            S_LAP: begin
                if (ev_start) begin
                    next_state = S_PAUSED;
                end else if (ev_lap) begin
                    next_state = S_RUNNING;
                end
            end
            S_PAUSED: begin
                if (ev_clear) begin
                    do_clear   = 1'b1;
                    next_state = S_IDLE;
                end else if (ev_start) begin
                    next_state = S_RUNNING;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State register, registered output decode and the tick prescaler that freezes while paused.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
            hold_q    <= 1'b0;
            clear_q   <= 1'b0;
            tick_q    <= 1'b0;
            pre_q     <= '0;
        end else begin
            state_q   <= next_state;
            running_q <= (next_state == S_RUNNING) || (next_state == S_LAP);
            hold_q    <= (next_state == S_LAP);
            clear_q   <= do_clear;
            tick_q    <= 1'b0;
            if (do_clear) begin
                pre_q <= '0;
            end else if ((state_q == S_RUNNING) || (state_q == S_LAP)) begin
                if (pre_q == PRE_MAX) begin
                    pre_q  <= '0;
                    tick_q <= 1'b1;
                end else begin
                    pre_q <= pre_q + 1'b1;
                end
            end
        end
    end

    assign bus.tick         = tick_q;
    assign bus.clear        = clear_q;
    assign bus.display_hold = hold_q;
    assign bus.running      = running_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int DB      = 4;

    logic clk;
    logic rst;
    stopwatch_ctrl_if bus();

    stopwatch_ctrl #(
        .CLK_HZ(CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // reference model: key history, debounced levels, scheduled events, stopwatch state
    int         e_no = 0;
    logic [3:0] kh [8];
    bit         rh [8];
    bit         m_deb [3];
    int         m_run [3];
    int         pend0 [$];
    int         pend1 [$];
    int         pend2 [$];
    int         m_state = 0;
    int         m_pre = 0;
    bit         m_tick = 0;
    bit         m_clear = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0d expected %0d", nm, e_no, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_deb[i] = 0;
            m_run[i] = 0;
        end
        pend0.delete();
        pend1.delete();
        pend2.delete();
        m_state = 0;
        m_pre   = 0;
        m_tick  = 0;
        m_clear = 0;
    endtask

    task automatic model_edge(input logic [3:0] k, input bit r);
        bit ev [3];
        bit seen;
        logic [3:0] old2;
        int s;
        e_no++;
        kh[e_no % 8] = r ? 4'hF : k;
        rh[e_no % 8] = r;
        if (r) begin
            model_reset();
            return;
        end
        ev[0] = (pend0.size() > 0) && (pend0[0] == e_no);
        ev[1] = (pend1.size() > 0) && (pend1[0] == e_no);
        ev[2] = (pend2.size() > 0) && (pend2[0] == e_no);
        if (ev[0]) void'(pend0.pop_front());
        if (ev[1]) void'(pend1.pop_front());
        if (ev[2]) void'(pend2.pop_front());
        // debouncer sees the key sampled two edges ago, or released if a reset intervened
        old2 = kh[(e_no + 6) % 8];
        for (int i = 0; i < 3; i++) begin
            seen = rh[(e_no + 7) % 8] ? 1'b0 : ~old2[i];
            if (seen != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_deb[i] = seen;
                    m_run[i] = 0;
                    if (seen) begin
                        if (i == 0) pend0.push_back(e_no + 2);
                        if (i == 1) pend1.push_back(e_no + 2);
                        if (i == 2) pend2.push_back(e_no + 2);
                    end
                end
            end else begin
                m_run[i] = 0;
            end
        end
        s = m_state;
        m_tick  = 0;
        m_clear = 0;
        if (s == 1 || s == 3) begin
            m_pre = (m_pre + 1) % DIV;
            if (m_pre == 0) m_tick = 1;
        end
        if (ev[2]) begin
            if (s == 0) m_clear = 1;
            if (s == 2) begin
                m_clear = 1;
                m_state = 0;
                m_pre   = 0;
            end
        end else if (ev[0]) begin
            m_state = (s == 0 || s == 2) ? 1 : 2;
        end else if (ev[1]) begin
            if (s == 1) m_state = 3;
            else if (s == 3) m_state = 1;
        end
    endtask

    task automatic step(input logic [3:0] k, input bit r);
        bus.KEY = k;
        rst     = r;
        @(posedge clk);
        model_edge(k, r);
        #1;
        chk("state",   int'(bus.state), m_state);
        chk("tick",    int'(bus.tick), int'(m_tick));
        chk("clear",   int'(bus.clear), int'(m_clear));
        chk("hold",    int'(bus.display_hold), (m_state == 3) ? 1 : 0);
        chk("running", int'(bus.running), (m_state == 1 || m_state == 3) ? 1 : 0);
    endtask

    typedef struct {
        logic [3:0] key;
        int         exp_state;
        bit         exp_hold;
        bit         exp_run;
        int         exp_clears;
    } vec_t;

    vec_t vt [15];

    initial begin
        int n;
        int act;
        int ticks;
        int clears;
        int hold;
        logic [3:0] k;

        for (int i = 0; i < 8; i++) begin
            kh[i] = 4'hF;
            rh[i] = 1'b1;
        end
        model_reset();
        bus.KEY = 4'hF;
        rst     = 1'b1;

        vt[0]  = '{4'hD, 3, 1, 1, 0};
        vt[1]  = '{4'hD, 1, 0, 1, 0};
        vt[2]  = '{4'hB, 1, 0, 1, 0};
        vt[3]  = '{4'hE, 2, 0, 0, 0};
        vt[4]  = '{4'hD, 2, 0, 0, 0};
        vt[5]  = '{4'hE, 1, 0, 1, 0};
        vt[6]  = '{4'hE, 2, 0, 0, 0};
        vt[7]  = '{4'hB, 0, 0, 0, 1};
        vt[8]  = '{4'hB, 0, 0, 0, 1};
        vt[9]  = '{4'hE, 1, 0, 1, 0};
        vt[10] = '{4'hE, 2, 0, 0, 0};
        vt[11] = '{4'hA, 0, 0, 0, 1};
        vt[12] = '{4'hE, 1, 0, 1, 0};
        vt[13] = '{4'hD, 3, 1, 1, 0};
        vt[14] = '{4'hE, 2, 0, 0, 0};

        // reset then a quiet idle period
        for (int i = 0; i < 3; i++) step(4'hF, 1);
        act = 0;
        for (int i = 0; i < 100; i++) begin
            step(4'hF, 0);
            if (bus.tick || bus.clear || bus.running || bus.display_hold || bus.state != 2'b00) act++;
        end
        chk("idle_quiet", act, 0);

        // bouncing start key never qualifies
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            step((i < 20 && ((i / 2) % 2 == 0)) ? 4'hE : 4'hF, 0);
            if (bus.tick) ticks++;
        end
        chk("bounce_state", int'(bus.state), 0);
        chk("bounce_ticks", ticks, 0);

        // start latency and first tick spacing
        step(4'hE, 0);
        n = e_no;
        for (int i = 1; i < 32; i++) begin
            step((i < 12) ? 4'hE : 4'hF, 0);
            if (e_no == n + 6)  chk("lat_before", int'(bus.state), 0);
            if (e_no == n + 7)  chk("lat_at", int'(bus.state), 1);
            if (e_no == n + 16) chk("tick_early", int'(bus.tick), 0);
            if (e_no == n + 17) chk("tick_first", int'(bus.tick), 1);
            if (e_no == n + 26) chk("tick_gap", int'(bus.tick), 0);
            if (e_no == n + 27) chk("tick_second", int'(bus.tick), 1);
        end

        // table-driven key presses through every state
        for (int v = 0; v < 15; v++) begin
            clears = 0;
            for (int i = 0; i < 18; i++) begin
                step((i < 8) ? vt[v].key : 4'hF, 0);
                if (bus.clear) clears++;
            end
            chk($sformatf("vec%0d_state", v), int'(bus.state), vt[v].exp_state);
            chk($sformatf("vec%0d_hold", v), int'(bus.display_hold), int'(vt[v].exp_hold));
            chk($sformatf("vec%0d_run", v), int'(bus.running), int'(vt[v].exp_run));
            chk($sformatf("vec%0d_clears", v), clears, vt[v].exp_clears);
        end

        // reset in the middle of running
        for (int i = 0; i < 18; i++) step((i < 8) ? 4'hE : 4'hF, 0);
        for (int i = 0; i < 25; i++) step(4'hF, 0);
        chk("pre_reset_run", int'(bus.running), 1);
        step(4'hF, 1);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_tick", int'(bus.tick), 0);
        chk("rst_running", int'(bus.running), 0);
        for (int i = 0; i < 3; i++) step(4'hF, 0);

        // key held through reset produces a single start
        for (int i = 0; i < 3; i++) step(4'hE, 1);
        for (int i = 0; i < 10; i++) step(4'hE, 0);
        chk("held_rst_state", int'(bus.state), 1);
        for (int i = 0; i < 30; i++) step(4'hE, 0);
        chk("held_rst_once", int'(bus.state), 1);
        for (int i = 0; i < 10; i++) step(4'hF, 0);

        // randomized key activity against the reference model
        for (int c = 0; c < 2200; ) begin
            if ($urandom_range(0, 149) == 0) begin
                hold = $urandom_range(1, 2);
                for (int i = 0; i < hold; i++) step(4'($urandom), 1);
                c += hold;
            end else begin
                k = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
                hold = $urandom_range(1, 14);
                for (int i = 0; i < hold; i++) step(k, 0);
                c += hold;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
